// File: rtl/boot_ram_pkg.sv
// Shared types and constants for the boot/code RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_ram_pkg;

  localparam int RAM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_AW   = 11;
  localparam int DW        = RAM_LANES * LANE_W;

  // Byte addresses below this are boot code and can be write-locked.
  localparam logic [WORD_AW+1:0] PROT_LIMIT_DEF = 13'h0900;
  localparam int                 MAX_WAIT_DEF   = 4;

  // Which requester the access in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/boot_ram_arbiter_if.sv
// CPU-side bus of the boot RAM arbiter: fetch port (I) and data port (D).
// Latency: responses (rvalid) follow an accepted request by one cycle.
// Backpressure: ready per port; no response backpressure.
// Ports: I = valid/ready/addr, rvalid/rdata; D = valid/ready/we/addr/wstrb/wdata,
// rvalid/rdata/err. master = CPU side, slave = arbiter side.
interface boot_ram_arbiter_if #(
  parameter int AW = 13
);
  logic          i_valid;
  logic          i_ready;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_valid;
  logic          d_ready;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_wstrb;
  logic [31:0]   d_wdata;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;

  modport master (
    output i_valid, i_addr, d_valid, d_we, d_addr, d_wstrb, d_wdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_valid, i_addr, d_valid, d_we, d_addr, d_wstrb, d_wdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/boot_ram_grant.sv
// Single-winner grant between I and D with an I starvation counter.
// Latency: grant is combinational in the request cycle.
// Backpressure: the loser sees no grant and must hold its request.
// Ports: clk, reset, i_valid/d_valid in; i_grant/d_grant out.
module boot_ram_grant #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic d_valid,
  output logic i_grant,
  output logic d_grant
);

  localparam int            WW   = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  // Consecutive cycles I has been valid and lost to D.
  logic [WW-1:0] wait_cnt;

  // D has priority; once I has lost MAX_WAIT times in a row it is forced through.
  always_comb begin
    i_grant = 1'b0;
    d_grant = 1'b0;
    if (!reset) begin
      if (i_valid && d_valid) begin
        if (wait_cnt == WMAX) i_grant = 1'b1;
        else                  d_grant = 1'b1;
      end else if (i_valid) begin
        i_grant = 1'b1;
      end else if (d_valid) begin
        d_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (i_valid && !i_grant) begin
      if (wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/boot_ram_arbiter.sv
// Shares the 4-lane boot/code RAM between CPU fetch (I) and data (D) ports,
// with write protection of the boot-code region.
// Latency: request issued to RAM in the accept cycle; response one cycle later.
// Backpressure: one access per cycle, loser's ready is low; responses cannot be stalled.
// Ports: clk, reset, wp_lock; bus (slave modport); ram_ce/oce/reset/wre/ad/din out, ram_dout in.
module boot_ram_arbiter
  import boot_ram_pkg::*;
#(
  parameter int            AW         = WORD_AW + 2,
  parameter logic [AW-1:0] PROT_LIMIT = AW'(PROT_LIMIT_DEF),
  parameter int            MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wp_lock,
  boot_ram_arbiter_if.slave    bus,
  output logic                 ram_ce,
  output logic                 ram_oce,
  output logic                 ram_reset,
  output logic [RAM_LANES-1:0] ram_wre,
  output logic [AW-3:0]        ram_ad,
  output logic [DW-1:0]        ram_din,
  input  logic [DW-1:0]        ram_dout
);

  logic          i_grant;
  logic          d_grant;
  logic          d_blocked;
  logic [AW-3:0] ad_hold;
  owner_t        owner_q;
  logic          d_wr_q;
  logic          d_blk_q;
  logic          unused_ok;

  // Fetch addresses are word aligned; the low bits carry no information.
  assign unused_ok = ^bus.i_addr[1:0];

  boot_ram_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.i_valid),
    .d_valid (bus.d_valid),
    .i_grant (i_grant),
    .d_grant (d_grant)
  );

  assign bus.i_ready = i_grant;
  assign bus.d_ready = d_grant;

  // Blocked writes still go through the pipeline so the requester gets an ack.
  assign d_blocked = bus.d_we && wp_lock && (bus.d_addr < PROT_LIMIT);

  assign ram_ce    = i_grant | d_grant;
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;
  assign ram_din   = bus.d_wdata;
  assign ram_wre   = (d_grant && bus.d_we && !d_blocked) ? bus.d_wstrb : '0;

  // Keep the address stable when idle so the RAM output does not move.
  always_comb begin
    ram_ad = ad_hold;
    if (d_grant)      ram_ad = bus.d_addr[AW-1:2];
    else if (i_grant) ram_ad = bus.i_addr[AW-1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      d_wr_q  <= 1'b0;
      d_blk_q <= 1'b0;
      ad_hold <= '0;
    end else begin
      ad_hold <= ram_ad;
      d_wr_q  <= bus.d_we;
      d_blk_q <= d_blocked;
      if (d_grant)      owner_q <= OWN_D;
      else if (i_grant) owner_q <= OWN_I;
      else              owner_q <= OWN_NONE;
    end
  end

  assign bus.i_rvalid = (owner_q == OWN_I);
  assign bus.i_rdata  = bus.i_rvalid ? ram_dout : '0;
  assign bus.d_rvalid = (owner_q == OWN_D);
  assign bus.d_rdata  = (bus.d_rvalid && !d_wr_q) ? ram_dout : '0;
  assign bus.d_err    = bus.d_rvalid && d_wr_q && d_blk_q;

endmodule
